// File: rtl/adc_interface.sv
// I2S master receiver for the stereo capture ADC: generates BCK/LRCK from capture_clk and writes each
// frame to the ADC FIFO as a left/right word pair. Optional build macro ADC_SEQ_TAG_EN adds frame tags.
module adc_interface #(
  parameter int unsigned lrck_divisor = 512,
  parameter int unsigned sample_bits  = 24
) (
  input  logic        capture_clk,
  input  logic        reset_n,
  output logic        adc_bck,
  output logic        adc_lrck,
  input  logic        adc_data_pin,
  output logic        adc_wren,
  output logic [31:0] adc_wr_data,
  input  logic        adc_almost_full,
  output logic        adc_overflow
);

  localparam int unsigned HALF = lrck_divisor / 2;
  localparam int unsigned CW   = $clog2(HALF);

  localparam logic [CW-1:0] CNT_MAX   = CW'(HALF - 1);
  localparam logic [CW-1:0] FIRST_BIT = CW'(3);
  localparam logic [CW-1:0] LAST_BIT  = CW'(2 * sample_bits + 1);
  localparam logic [CW-1:0] DECIDE    = CW'(2 * sample_bits + 2);

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_LEFT,
    WR_RIGHT
  } wr_state_t;

  logic [CW-1:0]          half_cnt;
  logic [sample_bits-1:0] shifter;
  logic [sample_bits-1:0] left_hold;
  wr_state_t              wr_state;
  wr_state_t              wr_next;
  logic                   sample_en;
  logic                   decide;
  logic                   drop;

  function automatic logic [31:0] align(input logic [sample_bits-1:0] w);
    return 32'(w) << (32 - sample_bits);
  endfunction

  // Odd counts inside periods 1..sample_bits are the BCK rising edges carrying data.
  always_comb begin
    sample_en = half_cnt[0] && (half_cnt >= FIRST_BIT) && (half_cnt <= LAST_BIT);
    decide    = adc_lrck && (half_cnt == DECIDE);
    drop      = decide && adc_almost_full;
  end

  always_ff @(posedge capture_clk) begin
    if (!reset_n) begin
      half_cnt <= CNT_MAX;
      adc_lrck <= 1'b1;
      adc_bck  <= 1'b0;
    end else begin
      adc_bck <= half_cnt[0];
      if (half_cnt == CNT_MAX) begin
        half_cnt <= '0;
        adc_lrck <= ~adc_lrck;
      end else begin
        half_cnt <= half_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge capture_clk) begin
    if (!reset_n) begin
      shifter      <= '0;
      left_hold    <= '0;
      adc_overflow <= 1'b0;
    end else begin
      if (sample_en)
        shifter <= {shifter[sample_bits-2:0], adc_data_pin};
      if (!adc_lrck && (half_cnt == DECIDE))
        left_hold <= shifter;
      if (drop)
        adc_overflow <= 1'b1;
    end
  end

`ifdef ADC_SEQ_TAG_EN
  logic [6:0] frame_cnt;

  // Advances at the end of every frame, whether it was written or dropped.
  always_ff @(posedge capture_clk) begin
    if (!reset_n)
      frame_cnt <= '0;
    else if (drop || (wr_state == WR_RIGHT))
      frame_cnt <= frame_cnt + 7'd1;
  end
`endif

  always_ff @(posedge capture_clk) begin
    if (!reset_n)
      wr_state <= WR_IDLE;
    else
      wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE:  if (decide && !adc_almost_full) wr_next = WR_LEFT;
      WR_LEFT:  wr_next = WR_RIGHT;
      WR_RIGHT: wr_next = WR_IDLE;
      default:  wr_next = WR_IDLE;
    endcase
  end

  // The shifter holds the right word untouched until the next left-half data bit.
  always_comb begin
    adc_wren    = 1'b0;
    adc_wr_data = '0;
    case (wr_state)
      WR_LEFT: begin
        adc_wren    = 1'b1;
        adc_wr_data = align(left_hold);
      end
      WR_RIGHT: begin
        adc_wren    = 1'b1;
        adc_wr_data = align(shifter);
      end
      default: ;
    endcase
`ifdef ADC_SEQ_TAG_EN
    if (wr_state != WR_IDLE)
      adc_wr_data[7:0] = {frame_cnt, (wr_state == WR_RIGHT)};
`endif
  end

endmodule
